// File: rtl/vme_rd_resp_tracker.sv
// ---------------------------------------------------------------------------
// vme_rd_resp_tracker
//
// Downstream companion of the wide tensor-load VME command generator. Every
// VME read command that fires is remembered (tag, burst length, readLen) in a
// small FIFO. Returning read-data beats are matched against the oldest
// outstanding command. Each beat's tag and last flag are checked, the first
// readLen beats of each burst are written to consecutive scratchpad rows, and
// a one-cycle done pulse is raised once the generator has finished and every
// burst has come back.
//
// Ports
//   clock, reset        clock; asynchronous active-low reset
//   io_start            begin a tensor load (only looked at while idle)
//   io_sramOffset       first scratchpad row of the load
//   io_genDone          generator has issued its final command
//   io_cmd_*            fired VME command: fire strobe, tag, len, readLen
//   io_cmd_ready        a FIFO slot is free (ANDed into the VME cmd ready)
//   io_vmeData_*        returning read-data beat stream (valid/ready handshake)
//   io_wr_*             registered scratchpad write port
//   io_busy, io_done    load in progress / one-cycle completion pulse
//   io_tagErr           sticky: a beat carried the wrong tag
//   io_lenErr           sticky: last flag disagreed with the beat count, or
//                       a command fired while the FIFO was full
// ---------------------------------------------------------------------------
module vme_rd_resp_tracker #(
    parameter int DATA_W  = 64,
    parameter int TAG_W   = 21,
    parameter int LEN_W   = 8,
    parameter int RLEN_W  = 9,
    parameter int SRAM_AW = 16,
    parameter int DEPTH   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_start,
    input  logic [SRAM_AW-1:0] io_sramOffset,
    input  logic               io_genDone,
    input  logic               io_cmd_fire,
    input  logic [TAG_W-1:0]   io_cmd_tag,
    input  logic [LEN_W-1:0]   io_cmd_len,
    input  logic [RLEN_W-1:0]  io_cmd_readLen,
    output logic               io_cmd_ready,
    input  logic               io_vmeData_valid,
    output logic               io_vmeData_ready,
    input  logic [DATA_W-1:0]  io_vmeData_data,
    input  logic [TAG_W-1:0]   io_vmeData_tag,
    input  logic               io_vmeData_last,
    output logic               io_wr_valid,
    output logic [SRAM_AW-1:0] io_wr_addr,
    output logic [DATA_W-1:0]  io_wr_data,
    output logic               io_busy,
    output logic               io_done,
    output logic               io_tagErr,
    output logic               io_lenErr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CMP_W = ((LEN_W > RLEN_W) ? LEN_W : RLEN_W) + 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [TAG_W-1:0]    r_tagMem  [DEPTH];
    logic [LEN_W-1:0]    r_lenMem  [DEPTH];
    logic [RLEN_W-1:0]   r_rlenMem [DEPTH];
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [PTR_W:0]      r_count;

    logic [LEN_W-1:0]    r_beatCnt;
    logic [SRAM_AW-1:0]  r_rowPtr;
    logic                r_wrValid;
    logic [SRAM_AW-1:0]  r_wrAddr;
    logic [DATA_W-1:0]   r_wrData;
    logic                r_tagErr;
    logic                r_lenErr;

    logic                w_full;
    logic                w_empty;
    logic                w_start;
    logic                w_push;
    logic                w_overflow;
    logic                w_accept;
    logic                w_lastBeat;
    logic                w_pop;
    logic                w_keep;
    logic [TAG_W-1:0]    w_headTag;
    logic [LEN_W-1:0]    w_headLen;
    logic [RLEN_W-1:0]   w_headReadLen;

    // Full/empty come from the registered count only, so a pop in the same
    // cycle never makes room for a push (no bypass path).
    assign w_full        = (r_count == FULL_CNT);
    assign w_empty       = (r_count == '0);
    assign w_headTag     = r_tagMem[r_rdPtr];
    assign w_headLen     = r_lenMem[r_rdPtr];
    assign w_headReadLen = r_rlenMem[r_rdPtr];

    assign w_start    = (r_state == IDLE) && io_start;
    assign w_push     = io_cmd_fire && (r_state == ACTIVE) && !w_full;
    assign w_overflow = io_cmd_fire && (r_state == ACTIVE) && w_full;
    assign w_accept   = io_vmeData_valid && io_vmeData_ready;
    assign w_lastBeat = (r_beatCnt == w_headLen);
    assign w_pop      = w_accept && w_lastBeat;
    // Beats past readLen are dropped; readLen above len+1 simply never
    // limits anything because the burst pops at len.
    assign w_keep     = CMP_W'(r_beatCnt) < CMP_W'(w_headReadLen);

    assign io_cmd_ready     = (r_state == ACTIVE) && !w_full;
    assign io_vmeData_ready = ((r_state == ACTIVE) || (r_state == DRAIN)) && !w_empty;
    assign io_busy          = (r_state != IDLE);
    assign io_done          = (r_state == DONE);
    assign io_wr_valid      = r_wrValid;
    assign io_wr_addr       = r_wrAddr;
    assign io_wr_data       = r_wrData;
    assign io_tagErr        = r_tagErr;
    assign io_lenErr        = r_lenErr;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A command fired together with io_genDone is still
    // pushed because the push decode looks at the current state.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (io_start) w_nextState = ACTIVE;
            ACTIVE:  if (io_genDone) w_nextState = DRAIN;
            DRAIN:   if (w_empty) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Command storage; contents are only meaningful while the count says so.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_tagMem[r_wrPtr]  <= io_cmd_tag;
            r_lenMem[r_wrPtr]  <= io_cmd_len;
            r_rlenMem[r_wrPtr] <= io_cmd_readLen;
        end
    end

    // FIFO pointers/count, beat counter, write address and sticky errors.
    // A start wipes everything left over from the previous load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_beatCnt <= '0;
            r_rowPtr  <= '0;
            r_tagErr  <= 1'b0;
            r_lenErr  <= 1'b0;
        end else if (w_start) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_beatCnt <= '0;
            r_rowPtr  <= io_sramOffset;
            r_tagErr  <= 1'b0;
            r_lenErr  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_beatCnt <= '0;
            end else if (w_accept) begin
                r_beatCnt <= r_beatCnt + LEN_W'(1);
            end
            if (w_accept && w_keep) begin
                r_rowPtr <= r_rowPtr + SRAM_AW'(1);
            end
            if (w_accept && (io_vmeData_tag != w_headTag)) begin
                r_tagErr <= 1'b1;
            end
            if ((w_accept && (io_vmeData_last != w_lastBeat)) || w_overflow) begin
                r_lenErr <= 1'b1;
            end
        end
    end

    // Registered scratchpad write, one cycle behind the accepted beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrValid <= 1'b0;
            r_wrAddr  <= '0;
            r_wrData  <= '0;
        end else begin
            r_wrValid <= w_accept && w_keep;
            if (w_accept && w_keep) begin
                r_wrAddr <= r_rowPtr;
                r_wrData <= io_vmeData_data;
            end
        end
    end

endmodule

// File: tb/tb_vme_rd_resp_tracker.sv
module tb_vme_rd_resp_tracker;

    localparam int DATA_W  = 64;
    localparam int TAG_W   = 21;
    localparam int LEN_W   = 8;
    localparam int RLEN_W  = 9;
    localparam int SRAM_AW = 16;
    localparam int DEPTH   = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               io_start;
    logic [SRAM_AW-1:0] io_sramOffset;
    logic               io_genDone;
    logic               io_cmd_fire;
    logic [TAG_W-1:0]   io_cmd_tag;
    logic [LEN_W-1:0]   io_cmd_len;
    logic [RLEN_W-1:0]  io_cmd_readLen;
    logic               io_cmd_ready;
    logic               io_vmeData_valid;
    logic               io_vmeData_ready;
    logic [DATA_W-1:0]  io_vmeData_data;
    logic [TAG_W-1:0]   io_vmeData_tag;
    logic               io_vmeData_last;
    logic               io_wr_valid;
    logic [SRAM_AW-1:0] io_wr_addr;
    logic [DATA_W-1:0]  io_wr_data;
    logic               io_busy;
    logic               io_done;
    logic               io_tagErr;
    logic               io_lenErr;

    vme_rd_resp_tracker #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .LEN_W(LEN_W),
        .RLEN_W(RLEN_W), .SRAM_AW(SRAM_AW), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .io_start(io_start),
        .io_sramOffset(io_sramOffset), .io_genDone(io_genDone),
        .io_cmd_fire(io_cmd_fire), .io_cmd_tag(io_cmd_tag),
        .io_cmd_len(io_cmd_len), .io_cmd_readLen(io_cmd_readLen),
        .io_cmd_ready(io_cmd_ready), .io_vmeData_valid(io_vmeData_valid),
        .io_vmeData_ready(io_vmeData_ready), .io_vmeData_data(io_vmeData_data),
        .io_vmeData_tag(io_vmeData_tag), .io_vmeData_last(io_vmeData_last),
        .io_wr_valid(io_wr_valid), .io_wr_addr(io_wr_addr),
        .io_wr_data(io_wr_data), .io_busy(io_busy), .io_done(io_done),
        .io_tagErr(io_tagErr), .io_lenErr(io_lenErr)
    );

    always #5 clock = ~clock;

    int nCompared = 0;
    int nMismatched = 0;

    // Behavioural reference: a queue of outstanding commands, a beat index
    // into the head burst, the next scratchpad row and the sticky flags.
    typedef struct {int tag; int len; int rlen;} cmd_t;
    typedef struct {int addr; logic [DATA_W-1:0] data;} wr_t;
    cmd_t mQ[$];
    wr_t  expWr[$];
    wr_t  gotWr[$];
    int   mState;      // 0 idle, 1 active, 2 drain, 3 done
    int   mBeat;
    int   mAddr;
    bit   mTagErr;
    bit   mLenErr;
    int   mSizeBefore;
    cmd_t mHead;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mState = 0; mQ.delete(); mBeat = 0; mAddr = 0; mTagErr = 0; mLenErr = 0;
        end else if (mState == 0) begin
            if (io_start) begin
                mState = 1; mAddr = int'(io_sramOffset); mQ.delete();
                mBeat = 0; mTagErr = 0; mLenErr = 0;
            end
        end else begin
            mSizeBefore = mQ.size();
            if ((mState == 1 || mState == 2) && mSizeBefore > 0 && io_vmeData_valid) begin
                mHead = mQ[0];
                if (mBeat < mHead.rlen) begin
                    expWr.push_back('{mAddr, io_vmeData_data});
                    mAddr = (mAddr + 1) % (2 ** SRAM_AW);
                end
                if (int'(io_vmeData_tag) != mHead.tag) mTagErr = 1;
                if (io_vmeData_last != (mBeat == mHead.len)) mLenErr = 1;
                if (mBeat == mHead.len) begin
                    void'(mQ.pop_front());
                    mBeat = 0;
                end else begin
                    mBeat++;
                end
            end
            if (mState == 1 && io_cmd_fire) begin
                if (mSizeBefore < DEPTH)
                    mQ.push_back('{int'(io_cmd_tag), int'(io_cmd_len), int'(io_cmd_readLen)});
                else
                    mLenErr = 1;
            end
            if (mState == 1 && io_genDone) mState = 2;
            else if (mState == 2 && mSizeBefore == 0) mState = 3;
            else if (mState == 3) mState = 0;
        end
    end

    // Record what the DUT writes, 1 time unit after each edge.
    always @(posedge clock) begin
        #1;
        if (io_wr_valid) gotWr.push_back('{int'(io_wr_addr), io_wr_data});
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clearInputs();
        io_start = 0; io_sramOffset = '0; io_genDone = 0; io_cmd_fire = 0;
        io_cmd_tag = '0; io_cmd_len = '0; io_cmd_readLen = '0;
        io_vmeData_valid = 0; io_vmeData_data = '0; io_vmeData_tag = '0;
        io_vmeData_last = 0;
    endtask

    task automatic doStart(input int off);
        io_start = 1; io_sramOffset = SRAM_AW'(off);
        tick();
        io_start = 0;
    endtask

    task automatic doFire(input int tag, input int len, input int rlen, input bit gd);
        io_cmd_fire = 1; io_cmd_tag = TAG_W'(tag); io_cmd_len = LEN_W'(len);
        io_cmd_readLen = RLEN_W'(rlen); io_genDone = gd;
        tick();
        io_cmd_fire = 0; io_genDone = 0;
    endtask

    task automatic doBeat(input logic [DATA_W-1:0] d, input int tag, input bit last);
        io_vmeData_valid = 1; io_vmeData_data = d;
        io_vmeData_tag = TAG_W'(tag); io_vmeData_last = last;
        tick();
        io_vmeData_valid = 0; io_vmeData_last = 0;
    endtask

    task automatic waitDone(input int budget, output bit seen);
        seen = 0;
        for (int k = 0; k < budget; k++) begin
            if (io_done) begin
                seen = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        clearInputs();
        reset = 0;
        io_start = 1; io_cmd_fire = 1; io_vmeData_valid = 1;
        tick(); tick();
        nCompared++;
        if ({io_wr_valid, io_busy, io_done, io_tagErr, io_lenErr, io_cmd_ready, io_vmeData_ready} !== 7'b0) begin
            nMismatched++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {io_wr_valid, io_busy, io_done, io_tagErr, io_lenErr, io_cmd_ready, io_vmeData_ready});
        end
        nCompared++;
        if (io_wr_addr !== '0 || io_wr_data !== '0) begin
            nMismatched++;
            $display("FAIL reset_wrport: got addr %h data %h expected 0", io_wr_addr, io_wr_data);
        end
        clearInputs();
        reset = 1;
        tick();
        nCompared++;
        if (io_busy !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_idle: got busy %b expected 0", io_busy);
        end
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] d [4];
        expWr.delete(); gotWr.delete();
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        doStart('h40);
        nCompared++;
        if (io_busy !== 1'b1 || io_cmd_ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL basic_active: got busy %b ready %b expected 1 1", io_busy, io_cmd_ready);
        end
        doFire(5, 3, 4, 1);
        for (int i = 0; i < 4; i++) begin
            doBeat(d[i], 5, i == 3);
            nCompared++;
            if (io_wr_valid !== 1'b1 || io_wr_addr !== SRAM_AW'('h40 + i) || io_wr_data !== d[i]) begin
                nMismatched++;
                $display("FAIL basic_write%0d: got v%b %h %h expected v1 %h %h",
                         i, io_wr_valid, io_wr_addr, io_wr_data, 'h40 + i, d[i]);
            end
        end
        nCompared++;
        if (io_done !== 1'b0) begin
            nMismatched++;
            $display("FAIL basic_done_early: got %b expected 0", io_done);
        end
        tick();
        nCompared++;
        if (io_done !== 1'b1 || io_wr_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL basic_done: got done %b wr %b expected 1 0", io_done, io_wr_valid);
        end
        tick();
        nCompared++;
        if (io_done !== 1'b0 || io_busy !== 1'b0) begin
            nMismatched++;
            $display("FAIL basic_done_once: got done %b busy %b expected 0 0", io_done, io_busy);
        end
        nCompared++;
        if (gotWr.size() != 4 || expWr.size() != 4 || io_tagErr !== 1'b0 || io_lenErr !== 1'b0) begin
            nMismatched++;
            $display("FAIL basic_summary: got %0d writes (model %0d) errs %b%b expected 4 writes errs 00",
                     gotWr.size(), expWr.size(), io_tagErr, io_lenErr);
        end
    endtask

    task automatic test_partial();
        logic [DATA_W-1:0] d [4];
        bit seen;
        expWr.delete(); gotWr.delete();
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        doStart('h40);
        doFire(9, 3, 2, 1);
        for (int i = 0; i < 4; i++) begin
            nCompared++;
            if (io_vmeData_ready !== 1'b1) begin
                nMismatched++;
                $display("FAIL partial_ready%0d: got %b expected 1", i, io_vmeData_ready);
            end
            doBeat(d[i], 9, i == 3);
            nCompared++;
            if (io_wr_valid !== (i < 2)) begin
                nMismatched++;
                $display("FAIL partial_wr%0d: got %b expected %b", i, io_wr_valid, i < 2);
            end
        end
        nCompared++;
        if (io_vmeData_ready !== 1'b0) begin
            nMismatched++;
            $display("FAIL partial_empty: got ready %b expected 0", io_vmeData_ready);
        end
        waitDone(10, seen);
        tick();
        nCompared++;
        if (!seen || gotWr.size() != 2) begin
            nMismatched++;
            $display("FAIL partial_done: got done %b writes %0d expected 1 2", seen, gotWr.size());
        end else begin
            nCompared++;
            if (gotWr[0].addr != 'h40 || gotWr[1].addr != 'h41 ||
                gotWr[0].data !== d[0] || gotWr[1].data !== d[1]) begin
                nMismatched++;
                $display("FAIL partial_rows: got %h/%h expected 40/41 with D0/D1",
                         gotWr[0].addr, gotWr[1].addr);
            end
        end
    endtask

    task automatic test_full();
        int tg [8];
        int ln [8];
        bit seen;
        expWr.delete(); gotWr.delete();
        doStart($urandom_range(0, 'hFFFF));
        for (int i = 0; i < 8; i++) begin
            tg[i] = $urandom_range(0, 'h1FFFFF);
            ln[i] = $urandom_range(0, 2);
            doFire(tg[i], ln[i], $urandom_range(0, 4), 0);
        end
        nCompared++;
        if (io_cmd_ready !== 1'b0 || io_vmeData_ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL full_ready: got cmd %b data %b expected 0 1", io_cmd_ready, io_vmeData_ready);
        end
        doFire(123, 0, 1, 0);
        nCompared++;
        if (io_lenErr !== 1'b1) begin
            nMismatched++;
            $display("FAIL full_overflow: got lenErr %b expected 1", io_lenErr);
        end
        for (int b = 0; b <= ln[0]; b++) begin
            if (b == ln[0]) begin
                nCompared++;
                if (io_cmd_ready !== 1'b0) begin
                    nMismatched++;
                    $display("FAIL full_nobypass: got %b expected 0", io_cmd_ready);
                end
            end
            doBeat({$urandom, $urandom}, tg[0], b == ln[0]);
        end
        nCompared++;
        if (io_cmd_ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL full_reopen: got %b expected 1", io_cmd_ready);
        end
        for (int c = 1; c < 8; c++)
            for (int b = 0; b <= ln[c]; b++)
                doBeat({$urandom, $urandom}, tg[c], b == ln[c]);
        io_genDone = 1; tick(); io_genDone = 0;
        waitDone(10, seen);
        tick();
        nCompared++;
        if (!seen || gotWr.size() != expWr.size() || io_lenErr !== mLenErr || io_tagErr !== mTagErr) begin
            nMismatched++;
            $display("FAIL full_drain: got done %b writes %0d errs %b%b expected 1 %0d %b%b",
                     seen, gotWr.size(), io_tagErr, io_lenErr, expWr.size(), mTagErr, mLenErr);
        end
        for (int i = 0; i < gotWr.size() && i < expWr.size(); i++) begin
            nCompared++;
            if (gotWr[i].addr != expWr[i].addr || gotWr[i].data !== expWr[i].data) begin
                nMismatched++;
                $display("FAIL full_write%0d: got %h %h expected %h %h", i,
                         gotWr[i].addr, gotWr[i].data, expWr[i].addr, expWr[i].data);
            end
        end
    endtask

    task automatic test_tagErr();
        bit seen;
        doStart(0);
        doFire(5, 1, 2, 1);
        doBeat({$urandom, $urandom}, 6, 0);
        nCompared++;
        if (io_tagErr !== 1'b1) begin
            nMismatched++;
            $display("FAIL tag_set: got %b expected 1", io_tagErr);
        end
        doBeat({$urandom, $urandom}, 5, 1);
        waitDone(10, seen);
        tick();
        nCompared++;
        if (!seen || io_tagErr !== 1'b1 || io_wr_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL tag_sticky: got done %b tagErr %b expected 1 1", seen, io_tagErr);
        end
        doStart(0);
        nCompared++;
        if (io_tagErr !== 1'b0 || io_lenErr !== 1'b0) begin
            nMismatched++;
            $display("FAIL tag_clear: got %b%b expected 00", io_tagErr, io_lenErr);
        end
        io_genDone = 1; tick(); io_genDone = 0;
        waitDone(10, seen);
        tick();
    endtask

    task automatic test_lenErr();
        bit seen;
        doStart(0);
        doFire(7, 3, 4, 1);
        for (int b = 0; b < 4; b++) begin
            doBeat({$urandom, $urandom}, 7, b == 1);
            nCompared++;
            if (io_lenErr !== (b >= 1) || io_vmeData_ready !== (b < 3)) begin
                nMismatched++;
                $display("FAIL len_beat%0d: got lenErr %b ready %b expected %b %b",
                         b, io_lenErr, io_vmeData_ready, b >= 1, b < 3);
            end
        end
        waitDone(10, seen);
        tick();
        nCompared++;
        if (!seen) begin
            nMismatched++;
            $display("FAIL len_done: got %b expected 1", seen);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        doStart('h100);
        for (int i = 1; i <= 3; i++) doFire(i, 3, 4, 0);
        doBeat({$urandom, $urandom}, 1, 0);
        doBeat({$urandom, $urandom}, 1, 0);
        reset = 0;
        #1;
        nCompared++;
        if ({io_wr_valid, io_busy, io_done, io_cmd_ready, io_vmeData_ready} !== 5'b0 ||
            io_wr_addr !== '0 || io_wr_data !== '0) begin
            nMismatched++;
            $display("FAIL midreset_outputs: got v%b b%b d%b cr%b dr%b a%h expected all 0",
                     io_wr_valid, io_busy, io_done, io_cmd_ready, io_vmeData_ready, io_wr_addr);
        end
        tick();
        reset = 1;
        tick();
        expWr.delete(); gotWr.delete();
        doStart('hFFFF);
        doFire(11, 1, 2, 1);
        doBeat(64'hA5A5, 11, 0);
        nCompared++;
        if (io_wr_valid !== 1'b1 || io_wr_addr !== 16'hFFFF) begin
            nMismatched++;
            $display("FAIL midreset_row0: got v%b %h expected v1 ffff", io_wr_valid, io_wr_addr);
        end
        doBeat(64'h5A5A, 11, 1);
        nCompared++;
        if (io_wr_valid !== 1'b1 || io_wr_addr !== 16'h0000) begin
            nMismatched++;
            $display("FAIL midreset_wrap: got v%b %h expected v1 0000", io_wr_valid, io_wr_addr);
        end
        waitDone(10, seen);
        tick();
    endtask

    task automatic test_random();
        bit seen;
        int nCmds;
        int issued;
        for (int load = 0; load < 4; load++) begin
            expWr.delete(); gotWr.delete();
            doStart($urandom_range(0, 'hFFFF));
            nCmds = $urandom_range(1, 12);
            issued = 0;
            seen = 0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                io_cmd_fire = 0; io_genDone = 0; io_vmeData_valid = 0; io_vmeData_last = 0;
                if (issued < nCmds && mState == 1 && mQ.size() < DEPTH && $urandom_range(0, 2) != 0) begin
                    io_cmd_fire = 1;
                    io_cmd_tag = TAG_W'($urandom_range(0, 31));
                    io_cmd_len = LEN_W'($urandom_range(0, 4));
                    io_cmd_readLen = RLEN_W'($urandom_range(0, 6));
                    issued++;
                end
                if (issued == nCmds && mState == 1) io_genDone = 1;
                if ((mState == 1 || mState == 2) && mQ.size() > 0 && $urandom_range(0, 3) != 0) begin
                    io_vmeData_valid = 1;
                    io_vmeData_data = {$urandom, $urandom};
                    io_vmeData_tag = TAG_W'(mQ[0].tag ^ ($urandom_range(0, 19) == 0 ? 1 : 0));
                    io_vmeData_last = (mBeat == mQ[0].len) ^ ($urandom_range(0, 19) == 0);
                end
                tick();
                nCompared++;
                if (io_cmd_ready !== (mState == 1 && mQ.size() < DEPTH) ||
                    io_vmeData_ready !== ((mState == 1 || mState == 2) && mQ.size() > 0)) begin
                    nMismatched++;
                    $display("FAIL rand_ready: got cmd %b data %b expected %b %b", io_cmd_ready,
                             io_vmeData_ready, mState == 1 && mQ.size() < DEPTH,
                             (mState == 1 || mState == 2) && mQ.size() > 0);
                end
                if (io_done) begin
                    seen = 1;
                    break;
                end
            end
            clearInputs();
            nCompared++;
            if (!seen || io_tagErr !== mTagErr || io_lenErr !== mLenErr || gotWr.size() != expWr.size()) begin
                nMismatched++;
                $display("FAIL rand_load%0d: got done %b errs %b%b writes %0d expected 1 %b%b %0d", load,
                         seen, io_tagErr, io_lenErr, gotWr.size(), mTagErr, mLenErr, expWr.size());
            end
            for (int i = 0; i < gotWr.size() && i < expWr.size(); i++) begin
                nCompared++;
                if (gotWr[i].addr != expWr[i].addr || gotWr[i].data !== expWr[i].data) begin
                    nMismatched++;
                    $display("FAIL rand_write%0d_%0d: got %h %h expected %h %h", load, i,
                             gotWr[i].addr, gotWr[i].data, expWr[i].addr, expWr[i].data);
                end
            end
            tick();
        end
    endtask

    initial begin
        clearInputs();
        test_reset();
        test_basic();
        test_partial();
        test_full();
        test_tagErr();
        test_lenErr();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
